// File: rtl/lcg_stim_gen_if.sv
// Stimulus-generator bus: run control (start/seed/cycles), the vector handshake and run status.
// The generator uses the master modport and the consumer/controller uses the slave modport.
interface lcg_stim_gen_if #(
    parameter int NUM_WORDS = 8
);
    logic                     start;
    logic [31:0]              seed;
    logic [31:0]              cycles;
    logic [32*NUM_WORDS-1:0]  in_flat;
    logic                     out_valid;
    logic                     out_ready;
    logic                     busy;
    logic                     done;
    logic [31:0]              vec_cnt;
    logic [31:0]              sig;

    modport master (
        input  start,
        input  seed,
        input  cycles,
        input  out_ready,
        output in_flat,
        output out_valid,
        output busy,
        output done,
        output vec_cnt,
        output sig
    );

    modport slave (
        output start,
        output seed,
        output cycles,
        output out_ready,
        input  in_flat,
        input  out_valid,
        input  busy,
        input  done,
        input  vec_cnt,
        input  sig
    );
endinterface

// File: rtl/lcg_stim_gen.sv
// LCG stimulus generator: fills NUM_WORDS 32-bit words per vector from one LCG and presents them with valid/ready.
// The optional rotate-XOR signature over accepted vectors is built only when LCG_STIM_GEN_SIG_EN is defined.
module lcg_stim_gen #(
    parameter int NUM_WORDS = 8
) (
    input  logic          clk,
    input  logic          rst,
    lcg_stim_gen_if.master bus
);
    localparam int               IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [31:0]      LCG_MUL  = 32'h41C64E6D;
    localparam logic [31:0]      LCG_INC  = 32'h0000_3039;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [31:0]             r_lcg;
    logic [31:0]             r_cycles;
    logic [31:0]             r_vecCnt;
    logic [IDX_W-1:0]        r_wordIdx;
    logic [32*NUM_WORDS-1:0] r_inFlat;

    logic                    w_startAccept;
    logic                    w_accept;
    logic                    w_lastWord;
    logic                    w_lastVector;
    logic [31:0]             w_lcgNext;

    // The only multiplier in the design; it is shared by every fill cycle.
    assign w_lcgNext     = r_lcg * LCG_MUL + LCG_INC;
    assign w_startAccept = bus.start && ((r_state == IDLE) || (r_state == DONE));
    assign w_accept      = (r_state == PRESENT) && bus.out_ready;
    assign w_lastWord    = (r_wordIdx == LAST_IDX);
    assign w_lastVector  = (r_vecCnt == r_cycles);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_nextState = FILL;
                end
            end
            FILL: begin
                if (w_lastWord) begin
                    w_nextState = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    w_nextState = w_lastVector ? DONE : FILL;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Words are written lowest first; untouched words keep the previous vector's value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lcg     <= '0;
            r_cycles  <= '0;
            r_vecCnt  <= '0;
            r_wordIdx <= '0;
            r_inFlat  <= '0;
        end else if (w_startAccept) begin
            r_lcg     <= bus.seed;
            r_cycles  <= bus.cycles;
            r_vecCnt  <= '0;
            r_wordIdx <= '0;
        end else if (r_state == FILL) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (r_wordIdx == IDX_W'(k)) begin
                    r_inFlat[32*k +: 32] <= w_lcgNext;
                end
            end
            r_lcg     <= w_lcgNext;
            r_wordIdx <= w_lastWord ? '0 : r_wordIdx + IDX_W'(1);
        end else if (w_accept) begin
            r_vecCnt  <= r_vecCnt + 32'd1;
        end
    end

    assign bus.in_flat   = r_inFlat;
    assign bus.out_valid = (r_state == PRESENT);
    assign bus.busy      = (r_state == FILL) || (r_state == PRESENT);
    assign bus.done      = (r_state == DONE);
    assign bus.vec_cnt   = r_vecCnt;

`ifdef LCG_STIM_GEN_SIG_EN
    logic [31:0] r_sig;
    logic [31:0] w_xorWords;

    always_comb begin
        w_xorWords = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            w_xorWords = w_xorWords ^ r_inFlat[32*k +: 32];
        end
    end

    // Rotate-left-by-one then fold in the accepted vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= '0;
        end else if (w_startAccept) begin
            r_sig <= '0;
        end else if (w_accept) begin
            r_sig <= {r_sig[30:0], r_sig[31]} ^ w_xorWords;
        end
    end

    assign bus.sig = r_sig;
`else
    assign bus.sig = '0;
`endif

endmodule

// File: tb/tb_lcg_stim_gen.sv
// Self-checking bench for lcg_stim_gen: table of runs checked against an arithmetic LCG model,
// plus hand-written reset-during-fill and restart sequences.
module tb_lcg_stim_gen;
    localparam int NW     = 8;
    localparam int VW     = 32 * NW;
    localparam int BUDGET = 200;

    typedef struct {
        logic [31:0] seed;
        logic [31:0] cycles;
        int          readyMode;
        bit          midStart;
        bit          hasKnown;
        logic [31:0] knownW0;
        logic [31:0] knownW1;
        logic [31:0] expVecCnt;
    } vector_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    vector_t tbl[$];

    always #5 clk = ~clk;

    lcg_stim_gen_if #(.NUM_WORDS(NW)) bus ();

    lcg_stim_gen #(.NUM_WORDS(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference LCG written directly from the recurrence in decimal with wide arithmetic.
    function automatic logic [31:0] lcgStep(input logic [31:0] s);
        logic [63:0] p;
        p = 64'(s) * 64'd1103515245 + 64'd12345;
        return p[31:0];
    endfunction

    function automatic logic [31:0] sigFold(input logic [31:0] prev, input logic [VW-1:0] vec);
        logic [31:0] acc;
        acc = {prev[30:0], prev[31]};
        for (int k = 0; k < NW; k++) begin
            acc = acc ^ vec[32*k +: 32];
        end
`ifndef LCG_STIM_GEN_SIG_EN
        acc = 32'd0;
`endif
        return acc;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic checkVector(input string name, input logic [VW-1:0] actual, input logic [VW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkVector($sformatf("%s.in_flat", tag), bus.in_flat, '0);
        checkOutput($sformatf("%s.vec_cnt", tag), bus.vec_cnt, 32'd0);
        checkOutput($sformatf("%s.sig", tag), bus.sig, 32'd0);
        checkOutput($sformatf("%s.out_valid", tag), 32'(bus.out_valid), 32'd0);
        checkOutput($sformatf("%s.busy", tag), 32'(bus.busy), 32'd0);
        checkOutput($sformatf("%s.done", tag), 32'(bus.done), 32'd0);
    endtask

    task automatic applyStimulus(input vector_t v, input string tag);
        logic [31:0]   s;
        logic [31:0]   sigM;
        logic [VW-1:0] expVec;
        int            cnt;
        int            stall;

        s    = v.seed;
        sigM = 32'd0;
        expVec = '0;
        bus.seed      = v.seed;
        bus.cycles    = v.cycles;
        bus.start     = 1'b1;
        bus.out_ready = (v.readyMode == 0);
        @(posedge clk); #1;
        // Scramble the run inputs so the DUT must rely on its latched copies.
        bus.start  = 1'b0;
        bus.seed   = ~v.seed;
        bus.cycles = 32'hFFFF_FFFF;
        checkOutput($sformatf("%s.busy_after_start", tag), 32'(bus.busy), 32'd1);
        checkOutput($sformatf("%s.done_cleared", tag), 32'(bus.done), 32'd0);
        cnt = 1;

        for (int n = 0; n <= int'(v.cycles); n++) begin
            for (int k = 0; k < NW; k++) begin
                s = lcgStep(s);
                expVec[32*k +: 32] = s;
            end

            while (!bus.out_valid && cnt < BUDGET) begin
                if (v.midStart && n == 0 && cnt == 3) begin
                    bus.start  = 1'b1;
                    bus.seed   = 32'hDEAD_BEEF;
                    bus.cycles = 32'd0;
                end else begin
                    bus.start = 1'b0;
                end
                @(posedge clk); #1;
                cnt++;
            end
            bus.start = 1'b0;
            if (!bus.out_valid) begin
                checkOutput($sformatf("%s.v%0d.timeout", tag, n), 32'd0, 32'd1);
                return;
            end

            // cnt is the index of the current cycle, counting the start (or accept) cycle as 0.
            checkOutput($sformatf("%s.v%0d.latency", tag, n), 32'(cnt), 32'(NW + 1));
            checkVector($sformatf("%s.v%0d.in_flat", tag, n), bus.in_flat, expVec);
            checkOutput($sformatf("%s.v%0d.vec_cnt_pre", tag, n), bus.vec_cnt, 32'(n));
            checkOutput($sformatf("%s.v%0d.sig_pre", tag, n), bus.sig, sigM);
            checkOutput($sformatf("%s.v%0d.busy", tag, n), 32'(bus.busy), 32'd1);
            if (v.hasKnown && n == 0) begin
                checkOutput($sformatf("%s.known_w0", tag), bus.in_flat[31:0], v.knownW0);
                checkOutput($sformatf("%s.known_w1", tag), bus.in_flat[63:32], v.knownW1);
            end

            stall = (v.readyMode == 2) ? 5 : ((v.readyMode == 1) ? int'($urandom_range(0, 3)) : 0);
            bus.out_ready = (stall == 0);
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                checkOutput($sformatf("%s.v%0d.stall%0d.valid", tag, n, i), 32'(bus.out_valid), 32'd1);
                checkVector($sformatf("%s.v%0d.stall%0d.in_flat", tag, n, i), bus.in_flat, expVec);
                checkOutput($sformatf("%s.v%0d.stall%0d.vec_cnt", tag, n, i), bus.vec_cnt, 32'(n));
                if (i == stall - 1) begin
                    bus.out_ready = 1'b1;
                end
            end

            @(posedge clk); #1;
            sigM = sigFold(sigM, expVec);
            checkOutput($sformatf("%s.v%0d.vec_cnt_post", tag, n), bus.vec_cnt, 32'(n + 1));
            checkOutput($sformatf("%s.v%0d.sig_post", tag, n), bus.sig, sigM);
            checkOutput($sformatf("%s.v%0d.valid_dropped", tag, n), 32'(bus.out_valid), 32'd0);
            bus.out_ready = (v.readyMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            cnt = 1;
        end

        checkOutput($sformatf("%s.done", tag), 32'(bus.done), 32'd1);
        checkOutput($sformatf("%s.busy_end", tag), 32'(bus.busy), 32'd0);
        checkOutput($sformatf("%s.vec_cnt_final", tag), bus.vec_cnt, v.expVecCnt);
        @(posedge clk); #1;
        checkOutput($sformatf("%s.done_held", tag), 32'(bus.done), 32'd1);
        checkOutput($sformatf("%s.valid_in_done", tag), 32'(bus.out_valid), 32'd0);
        checkVector($sformatf("%s.in_flat_retained", tag), bus.in_flat, expVec);
        checkOutput($sformatf("%s.sig_retained", tag), bus.sig, sigM);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vector_t e;

        tbl.push_back('{32'd0,          32'd0, 0, 1'b0, 1'b1, 32'h0000_3039, 32'hD3DC_167E, 32'd1});
        tbl.push_back('{32'd3965395580, 32'd3, 0, 1'b0, 1'b0, 32'd0,         32'd0,         32'd4});
        tbl.push_back('{32'h0BAD_F00D,  32'd1, 2, 1'b0, 1'b0, 32'd0,         32'd0,         32'd2});
        tbl.push_back('{32'h1234_5678,  32'd1, 0, 1'b1, 1'b0, 32'd0,         32'd0,         32'd2});
        tbl.push_back('{32'd0,          32'd1, 0, 1'b0, 1'b1, 32'h0000_3039, 32'hD3DC_167E, 32'd2});
        for (int r = 0; r < 4; r++) begin
            e.seed      = $urandom;
            e.cycles    = 32'($urandom_range(0, 3));
            e.readyMode = 1;
            e.midStart  = 1'b0;
            e.hasKnown  = 1'b0;
            e.knownW0   = 32'd0;
            e.knownW1   = 32'd0;
            e.expVecCnt = e.cycles + 32'd1;
            tbl.push_back(e);
        end

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.seed      = 32'd0;
        bus.cycles    = 32'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            applyStimulus(tbl[i], $sformatf("run%0d", i));
        end

        // Reset lands in the third fill cycle of a fresh run and must clear everything without a clock.
        bus.seed      = 32'd0;
        bus.cycles    = 32'd0;
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("midfill.busy_before_rst", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkAllZero("midfill_rst");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(tbl[0], "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcg_stim_gen.md
LCG_STIM_GEN -- requirements
Module: lcg_stim_gen

Interface
- REQ-001 SHALL have parameter NUM_WORDS, default 8, meaning the number of 32-bit words per stimulus vector.
- REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
- REQ-004 SHALL have port start, input, 1 bit: a one-cycle request to begin a run.
- REQ-005 SHALL have port seed, input, 32 bits: the initial LCG state, sampled when start is accepted.
- REQ-006 SHALL have port cycles, input, 32 bits: the number of vectors after the first, sampled when start is accepted.
- REQ-007 SHALL have port in_flat, output, 32*NUM_WORDS bits: the stimulus vector driven to the DUT.
- REQ-008 SHALL have port out_valid, output, 1 bit: in_flat holds a complete vector.
- REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the vector.
- REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE and DONE.
- REQ-011 SHALL have port done, output, 1 bit: held high while in DONE.
- REQ-012 SHALL have port vec_cnt, output, 32 bits: the number of vectors accepted in the current run.
- REQ-013 SHALL have port sig, output, 32 bits: the running signature (see Configuration).

Function
- REQ-014 SHALL compute the next LCG state as s' = (s * 32'h41C64E6D + 32'h3039) mod 2^32, with one update per FILL cycle, using a single multiplier.
- REQ-015 SHALL have FSM states IDLE, FILL, PRESENT and DONE.
- REQ-016 In IDLE or DONE, start=1 SHALL load the LCG state from seed, latch cycles, clear vec_cnt, clear done and go to FILL.
- REQ-017 FILL SHALL take exactly NUM_WORDS cycles.
  - On fill cycle k (k = 0..NUM_WORDS-1), it SHALL write s' into in_flat[32k+31:32k] and update the state to s'.
  - The lowest word SHALL be filled first.
  - After the last word, the FSM SHALL go to PRESENT.
- REQ-018 PRESENT SHALL drive out_valid=1 and hold in_flat stable until out_ready=1.
- REQ-019 A cycle with out_valid && out_ready SHALL be an acceptance.
  - On acceptance, vec_cnt SHALL increment.
  - If vec_cnt (the pre-increment value) equals the latched cycles value, the FSM SHALL go to DONE; otherwise it SHALL go to FILL.
- REQ-020 A run SHALL therefore produce cycles+1 vectors; with cycles=0, exactly one vector is produced.
- REQ-021 out_valid SHALL be 0 in FILL, IDLE and DONE.
- REQ-022 Latency from accepted start to the first out_valid SHALL be NUM_WORDS+1 cycles.
- REQ-023 start while busy SHALL be ignored, with no effect on the state, the counters or the LCG.
- REQ-024 in_flat SHALL retain its last value in IDLE and DONE, and during FILL for words not yet rewritten.
- REQ-025 vec_cnt SHALL wrap modulo 2^32 without error; the termination compare uses the full 32 bits.

Reset
- REQ-026 On rst assertion, the FSM SHALL go to IDLE immediately, regardless of clk.
- REQ-027 On rst assertion, in_flat, the LCG state, vec_cnt, sig, out_valid, busy and done SHALL all become 0, including mid-FILL or mid-PRESENT.
- REQ-028 The first start after rst deassertion SHALL be honoured on the first rising clk edge where rst=0.

Configuration
- REQ-029 The macro LCG_STIM_GEN_SIG_EN SHALL control the signature feature.
  - Defined: on each acceptance, sig <= {sig[30:0], sig[31]} XOR (the XOR of all NUM_WORDS 32-bit words of in_flat).
  - sig SHALL be cleared on an accepted start.
- REQ-030 Without LCG_STIM_GEN_SIG_EN, sig SHALL be constant 0 and no signature register SHALL be synthesised.

Verification
- REQ-031 Scenario 1: seed=0, cycles=0, out_ready=1.
  - Expected: in_flat[31:0]=32'h00003039, in_flat[63:32]=32'hD3DC167E.
  - Expected: out_valid for exactly 1 cycle, 9 cycles after start; then done=1 and vec_cnt=1.
- REQ-032 Scenario 2: seed=3965395580, cycles=3, out_ready=1.
  - Expected: 4 vectors, each word matching a software LCG model in word order.
  - Expected: done after the 4th acceptance, and vec_cnt=4.
- REQ-033 Scenario 3: out_ready=0 for 5 cycles in PRESENT.
  - Expected: in_flat and out_valid unchanged all 5 cycles, and vec_cnt unchanged.
  - Expected: on out_ready=1, a single increment.
- REQ-034 Scenario 4: start pulsed during FILL with a different seed.
  - Expected: the output sequence is identical to the run without the extra pulse.
- REQ-035 Scenario 5: rst asserted during the third FILL cycle.
  - Expected: all outputs 0 asynchronously and the FSM in IDLE.
  - Expected: a subsequent start with seed=0 reproduces Scenario 1 exactly.
- REQ-036 Scenario 6 (LCG_STIM_GEN_SIG_EN defined): seed=0, cycles=1.
  - Expected: sig matches the model after each acceptance.
  - Expected: with the macro undefined, sig=0 throughout.
